// File: rtl/bist_pkg.sv
// Shared BIST definitions: address ordering modes and the address sequencer state encoding.
package bist_pkg;

  localparam logic [1:0] ADDR_MODE_LINEAR = 2'd0;
  localparam logic [1:0] ADDR_MODE_GRAY   = 2'd1;
  localparam logic [1:0] ADDR_MODE_BITREV = 2'd2;
  localparam logic [1:0] ADDR_MODE_RSVD   = 2'd3;

  typedef enum logic {
    AG_IDLE = 1'b0,
    AG_RUN  = 1'b1
  } ag_state_t;

endpackage

// File: rtl/addr_scrambler.sv
// Purely combinational address mapping: linear, Gray or bit-reversed.
// Non-power-of-2 arrays fall back to linear so the result always stays in range.
module addr_scrambler
  import bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter bit POW2       = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] pos,
  input  logic [1:0]            mode,
  output logic [ADDR_WIDTH-1:0] addr
);

  logic [ADDR_WIDTH-1:0] rev;

  always_comb begin
    rev = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      rev[i] = pos[ADDR_WIDTH-1-i];
    end
    addr = pos;
    if (POW2) begin
      case (mode)
        ADDR_MODE_GRAY:   addr = pos ^ (pos >> 1);
        ADDR_MODE_BITREV: addr = rev;
        default:          addr = pos;
      endcase
    end
  end

endmodule

// File: rtl/march_addr_gen.sv
// March-element address sequencer: walks a latched [lo..hi] window up or down, one step per en,
// and reports last address / completion to the BIST controller.
module march_addr_gen
  import bist_pkg::*;
#(
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_WIDTH = $clog2(ARRAY_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dir_down,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] addr_lo,
  input  logic [ADDR_WIDTH-1:0] addr_hi,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  busy,
  output logic                  last,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(ARRAY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam bit                    POW2     = ((ARRAY_SIZE & (ARRAY_SIZE - 1)) == 0);

  ag_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] pos, pos_nxt, end_pos, end_nxt;
  logic [ADDR_WIDTH-1:0] lo_c, hi_c, win_lo, win_hi, map_nxt;
  logic [1:0]            mode_q, mode_nxt;
  logic                  dir_q, dir_nxt, done_nxt;

  // Compare one bit wider so the clamp stays a real comparison for power-of-2 sizes.
  always_comb begin
    lo_c   = ({1'b0, addr_lo} > {1'b0, MAX_ADDR}) ? MAX_ADDR : addr_lo;
    hi_c   = ({1'b0, addr_hi} > {1'b0, MAX_ADDR}) ? MAX_ADDR : addr_hi;
    win_lo = (lo_c > hi_c) ? hi_c : lo_c;
    win_hi = (lo_c > hi_c) ? lo_c : hi_c;
  end

  assign busy = (state == AG_RUN);
  assign last = busy && (pos == end_pos);

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    end_nxt   = end_pos;
    dir_nxt   = dir_q;
    mode_nxt  = mode_q;
    done_nxt  = 1'b0;
    case (state)
      AG_IDLE: begin
        if (start && !done) begin
          state_nxt = AG_RUN;
          pos_nxt   = dir_down ? win_hi : win_lo;
          end_nxt   = dir_down ? win_lo : win_hi;
          dir_nxt   = dir_down;
          mode_nxt  = mode;
        end
      end
      AG_RUN: begin
        if (abort) begin
          state_nxt = AG_IDLE;
        end else if (en) begin
          if (pos == end_pos) begin
            state_nxt = AG_IDLE;
            done_nxt  = 1'b1;
          end else begin
            pos_nxt = dir_q ? (pos - ONE) : (pos + ONE);
          end
        end
      end
      default: state_nxt = AG_IDLE;
    endcase
  end

  // Mapping the next position keeps addr_out registered yet aligned with pos.
  addr_scrambler #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .POW2      (POW2)
  ) u_scrambler (
    .pos (pos_nxt),
    .mode(mode_nxt),
    .addr(map_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= AG_IDLE;
      pos      <= '0;
      end_pos  <= '0;
      dir_q    <= 1'b0;
      mode_q   <= ADDR_MODE_LINEAR;
      addr_out <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      end_pos  <= end_nxt;
      dir_q    <= dir_nxt;
      mode_q   <= mode_nxt;
      addr_out <= map_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_march_addr_gen.sv
// Directed bench for march_addr_gen: a 16-word instance plus a 12-word instance for clamp and
// non-power-of-2 mapping behaviour.
module tb_march_addr_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start12 = 1'b0, abort = 1'b0, dir_down = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] lo = 4'd0, hi = 4'd0;
  logic [3:0] addr, addr12;
  logic       busy, last, done, busy12, last12, done12;

  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  march_addr_gen #(.ARRAY_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dir_down(dir_down), .mode(mode),
    .addr_lo(lo), .addr_hi(hi), .en(en),
    .addr_out(addr), .busy(busy), .last(last), .done(done)
  );

  march_addr_gen #(.ARRAY_SIZE(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .abort(abort), .dir_down(dir_down), .mode(mode),
    .addr_lo(lo), .addr_hi(hi), .en(en),
    .addr_out(addr12), .busy(busy12), .last(last12), .done(done12)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sweep(input logic [3:0] l, input logic [3:0] h, input logic d,
                             input logic [1:0] m);
    lo = l; hi = h; dir_down = d; mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    vec++;
    if ({addr, busy, last, done} !== 7'd0) begin
      bad++;
      $display("FAIL reset16: got addr=%0d busy=%b last=%b done=%b, want all 0", addr, busy, last, done);
    end
    vec++;
    if ({addr12, busy12, last12, done12} !== 7'd0) begin
      bad++;
      $display("FAIL reset12: got addr=%0d busy=%b last=%b done=%b, want all 0",
               addr12, busy12, last12, done12);
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_linear_up;
    logic [3:0] ea;
    en = 1'b1;
    begin_sweep(4'd0, 4'd15, 1'b0, 2'd0);
    for (int i = 0; i < 16; i++) begin
      ea = 4'(i);
      vec++;
      if ({addr, busy, last, done} !== {ea, 1'b1, (i == 15), 1'b0}) begin
        bad++;
        $display("FAIL lin_up[%0d]: got addr=%0d busy=%b last=%b done=%b, want addr=%0d busy=1 last=%b done=0",
                 i, addr, busy, last, done, ea, (i == 15));
      end
      tick();
    end
    vec++;
    if ({addr, busy, last, done} !== {4'd15, 3'b001}) begin
      bad++;
      $display("FAIL lin_up_done: got addr=%0d busy=%b last=%b done=%b, want 15 0 0 1", addr, busy, last, done);
    end
    en = 1'b0;
    tick();
    vec++;
    if ({addr, busy, last, done} !== {4'd15, 3'b000}) begin
      bad++;
      $display("FAIL lin_up_after: got addr=%0d busy=%b last=%b done=%b, want 15 0 0 0", addr, busy, last, done);
    end
  endtask

  task automatic test_down_toggle;
    int e[8] = '{6, 6, 5, 5, 4, 4, 3, 3};
    logic [3:0] ea;
    en = 1'b0;
    begin_sweep(4'd3, 4'd6, 1'b1, 2'd0);
    for (int k = 0; k < 8; k++) begin
      ea = 4'(e[k]);
      vec++;
      if ({addr, busy, last, done} !== {ea, 1'b1, (e[k] == 3), 1'b0}) begin
        bad++;
        $display("FAIL down_tog[%0d]: got addr=%0d busy=%b last=%b done=%b, want addr=%0d busy=1 last=%b done=0",
                 k, addr, busy, last, done, ea, (e[k] == 3));
      end
      en = (k % 2 == 1);
      tick();
    end
    vec++;
    if ({addr, busy, last, done} !== {4'd3, 3'b001}) begin
      bad++;
      $display("FAIL down_done: got addr=%0d busy=%b last=%b done=%b, want 3 0 0 1", addr, busy, last, done);
    end
    en = 1'b0;
    tick();
    vec++;
    if ({addr, busy, last, done} !== {4'd3, 3'b000}) begin
      bad++;
      $display("FAIL down_hold: got addr=%0d busy=%b last=%b done=%b, want 3 0 0 0", addr, busy, last, done);
    end
  endtask

  task automatic test_window;
    logic [3:0] ea;
    en = 1'b1;
    begin_sweep(4'd9, 4'd2, 1'b0, 2'd0);
    for (int i = 2; i <= 9; i++) begin
      ea = 4'(i);
      vec++;
      if ({addr, busy, last} !== {ea, 1'b1, (i == 9)}) begin
        bad++;
        $display("FAIL swap[%0d]: got addr=%0d busy=%b last=%b, want addr=%0d busy=1 last=%b",
                 i, addr, busy, last, ea, (i == 9));
      end
      tick();
    end
    vec++;
    if ({addr, busy, done} !== {4'd9, 2'b01}) begin
      bad++;
      $display("FAIL swap_done: got addr=%0d busy=%b done=%b, want 9 0 1", addr, busy, done);
    end
    // 12-word array: both bounds above 11 clamp to 11, giving a one-address window.
    en = 1'b0; lo = 4'd14; hi = 4'd13; dir_down = 1'b0; mode = 2'd0;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    vec++;
    if ({addr12, busy12, last12, done12} !== {4'd11, 3'b110}) begin
      bad++;
      $display("FAIL clamp: got addr=%0d busy=%b last=%b done=%b, want 11 1 1 0",
               addr12, busy12, last12, done12);
    end
    en = 1'b1;
    tick();
    vec++;
    if ({addr12, busy12, last12, done12} !== {4'd11, 3'b001}) begin
      bad++;
      $display("FAIL clamp_done: got addr=%0d busy=%b last=%b done=%b, want 11 0 0 1",
               addr12, busy12, last12, done12);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_mapping;
    int g[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    int b[4] = '{0, 8, 4, 12};
    logic [3:0] ea;
    en = 1'b1;
    begin_sweep(4'd0, 4'd7, 1'b0, 2'd1);
    for (int i = 0; i < 8; i++) begin
      ea = 4'(g[i]);
      vec++;
      if ({addr, last} !== {ea, (i == 7)}) begin
        bad++;
        $display("FAIL gray[%0d]: got addr=%0d last=%b, want addr=%0d last=%b", i, addr, last, ea, (i == 7));
      end
      tick();
    end
    vec++;
    if ({addr, done} !== {4'd4, 1'b1}) begin
      bad++;
      $display("FAIL gray_done: got addr=%0d done=%b, want 4 1", addr, done);
    end
    tick();
    begin_sweep(4'd0, 4'd3, 1'b0, 2'd2);
    for (int i = 0; i < 4; i++) begin
      ea = 4'(b[i]);
      vec++;
      if ({addr, last} !== {ea, (i == 3)}) begin
        bad++;
        $display("FAIL bitrev[%0d]: got addr=%0d last=%b, want addr=%0d last=%b", i, addr, last, ea, (i == 3));
      end
      tick();
    end
    vec++;
    if ({addr, done} !== {4'd12, 1'b1}) begin
      bad++;
      $display("FAIL bitrev_done: got addr=%0d done=%b, want 12 1", addr, done);
    end
    tick();
    // Gray request on the 12-word array must come out linear.
    lo = 4'd0; hi = 4'd3; dir_down = 1'b0; mode = 2'd1;
    start12 = 1'b1;
    tick();
    start12 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = 4'(i);
      vec++;
      if (addr12 !== ea) begin
        bad++;
        $display("FAIL gray12[%0d]: got addr=%0d, want %0d", i, addr12, ea);
      end
      tick();
    end
    vec++;
    if (done12 !== 1'b1) begin
      bad++;
      $display("FAIL gray12_done: got done=%b, want 1", done12);
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_single_and_abort;
    en = 1'b0;
    begin_sweep(4'd5, 4'd5, 1'b0, 2'd0);
    vec++;
    if ({addr, busy, last, done} !== {4'd5, 3'b110}) begin
      bad++;
      $display("FAIL single: got addr=%0d busy=%b last=%b done=%b, want 5 1 1 0", addr, busy, last, done);
    end
    lo = 4'd0; hi = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if ({addr, busy, last, done} !== {4'd5, 3'b110}) begin
      bad++;
      $display("FAIL restart_run: got addr=%0d busy=%b last=%b done=%b, want 5 1 1 0", addr, busy, last, done);
    end
    en = 1'b1;
    tick();
    en = 1'b0;
    vec++;
    if ({addr, busy, last, done} !== {4'd5, 3'b001}) begin
      bad++;
      $display("FAIL single_done: got addr=%0d busy=%b last=%b done=%b, want 5 0 0 1", addr, busy, last, done);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    vec++;
    if ({addr, busy, last, done} !== {4'd5, 3'b000}) begin
      bad++;
      $display("FAIL start_in_done: got addr=%0d busy=%b last=%b done=%b, want 5 0 0 0", addr, busy, last, done);
    end
    en = 1'b1;
    begin_sweep(4'd0, 4'd15, 1'b0, 2'd0);
    tick();
    tick();
    vec++;
    if ({addr, busy} !== {4'd2, 1'b1}) begin
      bad++;
      $display("FAIL pre_abort: got addr=%0d busy=%b, want 2 1", addr, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vec++;
    if ({addr, busy, last, done} !== {4'd2, 3'b000}) begin
      bad++;
      $display("FAIL abort: got addr=%0d busy=%b last=%b done=%b, want 2 0 0 0", addr, busy, last, done);
    end
    tick();
    vec++;
    if ({addr, busy, last, done} !== {4'd2, 3'b000}) begin
      bad++;
      $display("FAIL abort_idle_en: got addr=%0d busy=%b last=%b done=%b, want 2 0 0 0", addr, busy, last, done);
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [3:0] ea;
    en = 1'b1;
    begin_sweep(4'd0, 4'd15, 1'b0, 2'd0);
    tick();
    tick();
    vec++;
    if ({addr, busy, last, done} !== {4'd2, 3'b100}) begin
      bad++;
      $display("FAIL pre_rst: got addr=%0d busy=%b last=%b done=%b, want 2 1 0 0", addr, busy, last, done);
    end
    #3 rst_n = 1'b0;
    #1;
    vec++;
    if ({addr, busy, last, done} !== 7'd0) begin
      bad++;
      $display("FAIL async_rst: got addr=%0d busy=%b last=%b done=%b, want all 0", addr, busy, last, done);
    end
    #2 rst_n = 1'b1;
    tick();
    vec++;
    if ({addr, busy, last, done} !== 7'd0) begin
      bad++;
      $display("FAIL post_rst: got addr=%0d busy=%b last=%b done=%b, want all 0", addr, busy, last, done);
    end
    begin_sweep(4'd4, 4'd6, 1'b0, 2'd0);
    for (int i = 4; i <= 6; i++) begin
      ea = 4'(i);
      vec++;
      if ({addr, busy, last} !== {ea, 1'b1, (i == 6)}) begin
        bad++;
        $display("FAIL rst_sweep[%0d]: got addr=%0d busy=%b last=%b, want addr=%0d busy=1 last=%b",
                 i, addr, busy, last, ea, (i == 6));
      end
      tick();
    end
    vec++;
    if ({addr, busy, done} !== {4'd6, 2'b01}) begin
      bad++;
      $display("FAIL rst_sweep_done: got addr=%0d busy=%b done=%b, want 6 0 1", addr, busy, done);
    end
    en = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_linear_up();
    test_down_toggle();
    test_window();
    test_mapping();
    test_single_and_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
